// File: rtl/cpu_pkg.sv
// Shared types and widths for the data-memory arbiter.
package cpu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DBG = 2'd2
    } arb_state_e;

    // Records which requester completed most recently; the other one wins a tie.
    typedef enum logic {
        RR_CPU_LAST = 1'b0,
        RR_DBG_LAST = 1'b1
    } rr_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: hold at the ceiling instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    // Count register, cleared by the active-low asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-way data-memory arbiter (CPU MEM stage vs. loader/debug port).
// One access in flight at a time; round-robin on ties; a requester whose
// done flag is high is ineligible so a held request is never serviced twice.
// Optional: define DMEM_ARB_PERF_EN to add stall/conflict perf counters.
module dmem_arbiter
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_o,
    output logic [31:0]       perf_conflict_o
`endif
);

    arb_state_e        state_q, state_d;
    rr_e               rr_q, rr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              cpu_done_q, cpu_done_d;
    logic              dbg_done_q, dbg_done_d;

    logic cpu_elig, dbg_elig;

    assign cpu_elig = cpu_req_i && !cpu_done_q;
    assign dbg_elig = dbg_req_i && !dbg_done_q;

    // Next-state: grant in IDLE, complete on mem_ready_i in BUSY_x.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_done_d  = 1'b0;
        dbg_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (dbg_elig && (!cpu_elig || rr_q == RR_CPU_LAST)) begin
                        state_d = BUSY_DBG;
                        we_d    = dbg_we_i;
                        addr_d  = dbg_addr_i;
                        wdata_d = dbg_wdata_i;
                    end else if (cpu_elig) begin
                        state_d = BUSY_CPU;
                        we_d    = cpu_we_i;
                        addr_d  = cpu_addr_i;
                        wdata_d = cpu_wdata_i;
                    end
                end
            end
            BUSY_CPU: begin
                if (mem_ready_i) begin
                    if (!we_q) cpu_rdata_d = mem_rdata_i;
                    cpu_done_d = 1'b1;
                    rr_d       = RR_CPU_LAST;
                    state_d    = IDLE;
                end
            end
            BUSY_DBG: begin
                if (mem_ready_i) begin
                    if (!we_q) dbg_rdata_d = mem_rdata_i;
                    dbg_done_d = 1'b1;
                    rr_d       = RR_DBG_LAST;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            rr_q        <= RR_CPU_LAST;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            dbg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_done_q  <= cpu_done_d;
            dbg_done_q  <= dbg_done_d;
        end
    end

    assign mem_en_o    = (state_q != IDLE);
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign dbg_ack_o   = dbg_done_q;
    // Combinational so the pipeline freezes in the same cycle it asks.
    assign cpu_stall_o = cpu_req_i && !cpu_done_q;

`ifdef DMEM_ARB_PERF_EN
    logic stall_inc, conflict_inc;

    assign stall_inc    = cpu_stall_o && start_i;
    assign conflict_inc = (state_q == IDLE) && start_i && cpu_elig && dbg_elig;

    sat_counter #(.W(32)) u_perf_stall (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (perf_stall_o)
    );

    sat_counter #(.W(32)) u_perf_conflict (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (conflict_inc),
        .cnt_o (perf_conflict_o)
    );
`endif

endmodule
